leds_ctrl: RTL
==============

Name: leds_ctrl

Overview:
Parametrised multi-channel LED driver for the iCEstick, the successor to the static all-on LED block. Each of NUM_LEDS channels has its own mode: OFF, ON, BLINK or PWM brightness. A global chase mode overrides the per-channel modes. Channels are configured through a single-cycle write port, and the block drives the board LED pins directly from registered outputs.

Parameters:
NUM_LEDS, 5, number of LED channels (1..16)
PWM_BITS, 8, PWM counter and duty width; one PWM period = 2^PWM_BITS ticks
TICK_DIV, 47, clk cycles per PWM tick (>=1); 12 MHz/47/256 gives a period of about 1 kHz
BLINK_DIV, 500, PWM periods per blink half-period (>=1)
RESET_ON, 1, 1: all channels reset to ON mode; 0: all channels reset to OFF mode

Ports:
clk  in  1  system clock, 12 MHz
rstn  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe, one cycle
cfg_ch  in  CHW=max(1,$clog2(NUM_LEDS))  target channel
cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 PWM
cfg_duty  in  PWM_BITS  PWM duty
chase_en  in  1  global chase override
led  out  NUM_LEDS  LED drive, active high, registered
blink_phase  out  1  current blink phase, registered
period_end  out  1  one-cycle pulse on PWM counter wrap

Behaviour:
- Reset (async, rstn=0):
  - led=0, blink_phase=0, period_end=0.
  - All counters=0.
  - mode[i]=RESET_ON?ON:OFF; duty_shadow[i]=duty_active[i]=0.
  - chase_idx=0, chase_en_d=0.
- After rstn deasserts, the first clk edge registers led from reset state (all ones if RESET_ON). Assertion of rstn mid-operation clears everything immediately; no partial state survives.
- Prescaler: tick_cnt counts 0..TICK_DIV-1. tick=1 when tick_cnt==TICK_DIV-1. With TICK_DIV=1, tick=1 every cycle.
- PWM counter: on tick, pwm_cnt increments and wraps 2^PWM_BITS-1 -> 0.
  - wrap = tick && pwm_cnt==max.
  - period_end is registered wrap, i.e. high the cycle after the wrap edge.
- Blink: on wrap, blink_cnt increments. When blink_cnt==BLINK_DIV-1 and wrap: blink_cnt<=0, blink_phase toggles.
- Config write (cfg_we=1, cfg_ch<NUM_LEDS): mode[ch]<=cfg_mode and duty_shadow[ch]<=cfg_duty on the same edge.
  - cfg_ch>=NUM_LEDS: write ignored, no state change.
- Duty update is glitch-free: duty_active[i]<=duty_shadow[i] only on wrap.
  - A write on the same cycle as wrap bypasses the shadow: duty_active takes cfg_duty directly.
- Per-channel next value, used when chase_en=0:
  - OFF: 0
  - ON: 1
  - BLINK: blink_phase
  - PWM: pwm_cnt < duty_active[i] (duty 0 = always off; max duty = high for 2^PWM_BITS-1 of every 2^PWM_BITS ticks)
- Chase: chase_en_d registers chase_en.
  - Rising edge (chase_en && !chase_en_d): chase_idx<=0.
  - Otherwise, each blink_phase toggle while chase_en=1 advances chase_idx, wrapping NUM_LEDS-1 -> 0.
  - While chase_en=1, next led is one-hot at chase_idx and per-channel modes are ignored but retained.
  - Clearing chase_en restores the mode-driven outputs on the next computed value.
- Latency: led is registered from current state, one cycle after any mode, chase or counter change. A config write at edge N appears on led at edge N+1.
- All arithmetic is unsigned. Counter widths are sized with $clog2 of their terminal value and must never overflow.

Decomposition:
- Package leds_pkg holds:
  - mode constants MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_PWM=2'd3
  - typedef mode_t (2-bit)
- Sub-module leds_timebase holds the prescaler, pwm_cnt, blink_cnt and blink_phase.
  - Outputs: tick, wrap, pwm_cnt, blink_phase, blink_toggle.
  - leds_ctrl instantiates leds_timebase once. Per-channel registers and the output mux stay in leds_ctrl.

Test Plan:
All scenarios use NUM_LEDS=5, PWM_BITS=3, TICK_DIV=1, BLINK_DIV=2 unless noted (period = 8 cycles, blink half-period = 16 cycles).
1. Reset, RESET_ON=1, release rstn -> led=5'b11111 one edge later. Assert rstn mid-run -> led=0 immediately (asynchronous).
2. Write ch2 PWM duty 3, ch0 OFF -> after the next wrap, led[2] is high 3 of every 8 cycles. Duty 0 -> led[2] stays low. Duty 7 -> led[2] is low exactly 1 cycle per period.
3. Change ch2 duty 3 -> 6 mid-period -> the current period keeps 3 high cycles and the next period has 6. A write on the wrap cycle takes effect in that same new period.
4. ch1 BLINK -> led[1] toggles every 16 cycles, in phase with blink_phase. period_end pulses every 8 cycles.
5. chase_en=1 -> led=00001, then 00010 ... 10000 -> 00001, advancing every 16 cycles. Deassert -> the previous modes resume. Reassert -> chase restarts at 00001.
6. Write with cfg_ch=5 and cfg_ch=7 -> no change to any led or internal register. A write with cfg_we=0 is ignored.

Source files
------------

// File: rtl/leds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : leds_pkg
// Brief    : Shared mode encoding and sizing helper for the LED driver.
// Revision : 1.0 - initial release
// ============================================================================
package leds_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_ON    = 2'd1;
    localparam mode_t MODE_BLINK = 2'd2;
    localparam mode_t MODE_PWM   = 2'd3;

    // Width able to hold 0..terminal-1, never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal <= 1) ? 1 : $clog2(terminal);
    endfunction

endpackage
`default_nettype wire

// File: rtl/leds_timebase.sv
`default_nettype none
// ============================================================================
// Module   : leds_timebase
// Brief    : Prescaler, PWM period counter and blink phase generator.
// Revision : 1.0 - initial release
// ============================================================================
module leds_timebase
    import leds_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int TICK_DIV  = 47,
    parameter int BLINK_DIV = 500
)(
    input  logic                clk,
    input  logic                rstn,
    output logic                tick,
    output logic                wrap,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                blink_phase,
    output logic                blink_toggle
);

    localparam int c_tick_w  = cnt_width(TICK_DIV);
    localparam int c_blink_w = cnt_width(BLINK_DIV);

    logic [c_tick_w-1:0]  tick_cnt_q,  tick_cnt_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q,   pwm_cnt_d;
    logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;

    always_comb begin
        tick         = (tick_cnt_q == c_tick_w'(TICK_DIV - 1));
        wrap         = tick && (pwm_cnt_q == '1);
        blink_toggle = wrap && (blink_cnt_q == c_blink_w'(BLINK_DIV - 1));

        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        if (wrap) begin
            blink_cnt_d = blink_toggle ? '0 : blink_cnt_q + 1'b1;
        end
        blink_phase_d = blink_phase_q ^ blink_toggle;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_q    <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign pwm_cnt     = pwm_cnt_q;
    assign blink_phase = blink_phase_q;

endmodule
`default_nettype wire

// File: rtl/leds_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : leds_ctrl
// Brief    : Multi-channel LED driver: OFF/ON/BLINK/PWM per channel plus chase.
// Revision : 1.0 - initial release
// ============================================================================
module leds_ctrl
    import leds_pkg::*;
#(
    parameter int  NUM_LEDS  = 5,
    parameter int  PWM_BITS  = 8,
    parameter int  TICK_DIV  = 47,
    parameter int  BLINK_DIV = 500,
    parameter bit  RESET_ON  = 1'b1,
    localparam int CHW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
)(
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic                chase_en,
    output logic [NUM_LEDS-1:0] led,
    output logic                blink_phase,
    output logic                period_end
);

    localparam mode_t c_reset_mode = RESET_ON ? MODE_ON : MODE_OFF;

    logic                w_tick;
    logic                w_wrap;
    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_blink_phase;
    logic                w_blink_toggle;
    logic [NUM_LEDS-1:0] w_wr_sel;

    mode_t               mode_q        [NUM_LEDS];
    mode_t               mode_d        [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_shadow_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_shadow_d [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_active_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_active_d [NUM_LEDS];
    logic [CHW-1:0]      chase_idx_q,    chase_idx_d;
    logic                chase_en_dly_q, chase_en_dly_d;
    logic [NUM_LEDS-1:0] led_q,          led_d;
    logic                period_end_q,   period_end_d;

    leds_timebase #(
        .PWM_BITS  (PWM_BITS),
        .TICK_DIV  (TICK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rstn         (rstn),
        .tick         (w_tick),
        .wrap         (w_wrap),
        .pwm_cnt      (w_pwm_cnt),
        .blink_phase  (w_blink_phase),
        .blink_toggle (w_blink_toggle)
    );

    // Out-of-range channel numbers match no index, so such writes are dropped.
    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_wr_sel[i] = cfg_we && (cfg_ch == CHW'(i));
        end
    end

    always_comb begin
        mode_d        = mode_q;
        duty_shadow_d = duty_shadow_q;
        duty_active_d = duty_active_q;
        led_d         = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_wr_sel[i]) begin
                mode_d[i]        = mode_t'(cfg_mode);
                duty_shadow_d[i] = cfg_duty;
            end
            // Active duty only moves at a period boundary to avoid runt pulses.
            if (w_wrap) begin
                duty_active_d[i] = w_wr_sel[i] ? cfg_duty : duty_shadow_q[i];
            end
            if (chase_en) begin
                led_d[i] = (chase_idx_q == CHW'(i));
            end else begin
                case (mode_q[i])
                    MODE_OFF:   led_d[i] = 1'b0;
                    MODE_ON:    led_d[i] = 1'b1;
                    MODE_BLINK: led_d[i] = w_blink_phase;
                    default:    led_d[i] = (w_pwm_cnt < duty_active_q[i]);
                endcase
            end
        end

        chase_en_dly_d = chase_en;
        chase_idx_d    = chase_idx_q;
        if (chase_en && !chase_en_dly_q) begin
            chase_idx_d = '0;
        end else if (chase_en && w_blink_toggle) begin
            chase_idx_d = (chase_idx_q == CHW'(NUM_LEDS - 1)) ? '0 : chase_idx_q + 1'b1;
        end

        period_end_d = w_wrap;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]        <= c_reset_mode;
                duty_shadow_q[i] <= '0;
                duty_active_q[i] <= '0;
            end
            chase_idx_q    <= '0;
            chase_en_dly_q <= 1'b0;
            led_q          <= '0;
            period_end_q   <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            duty_shadow_q  <= duty_shadow_d;
            duty_active_q  <= duty_active_d;
            chase_idx_q    <= chase_idx_d;
            chase_en_dly_q <= chase_en_dly_d;
            led_q          <= led_d;
            period_end_q   <= period_end_d;
        end
    end

    a_wrap_on_tick: assert property (@(posedge clk) disable iff (!rstn) w_wrap |-> w_tick);

    assign led         = led_q;
    assign blink_phase = w_blink_phase;
    assign period_end  = period_end_q;

endmodule
`default_nettype wire
